// File: rtl/controle_poli.sv
// rtl/controle_poli.sv - Moore controller sequencing the A*X*X+B*X+C / A*X+B evaluation datapath
// Outputs decode only from state_q and mode_q; unused encodings fall back to IDLE.
module controle_poli (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  input  logic       lin,
  output logic       lx,
  output logic [1:0] m0,
  output logic [1:0] m1,
  output logic [1:0] m2,
  output logic       h,
  output logic       ls,
  output logic       lh,
  output logic       done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MUL_AX = 3'd2,
    S_ADD_B  = 3'd3,
    S_MUL_HX = 3'd4,
    S_ADD_C  = 3'd5,
    S_FIM    = 3'd6
  } state_e;

  state_e state_q, state_d;
  logic   mode_q, mode_d;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // mode_q is only rewritten on acceptance in IDLE, so start while busy cannot disturb it
  always_comb begin
    state_d = S_IDLE;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = lin;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD:   state_d = S_MUL_AX;
      S_MUL_AX: state_d = S_ADD_B;
      S_ADD_B:  state_d = mode_q ? S_FIM : S_MUL_HX;
      S_MUL_HX: state_d = S_ADD_C;
      S_ADD_C:  state_d = S_FIM;
      S_FIM:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lx   = 1'b0;
    m0   = 2'b00;
    m1   = 2'b00;
    m2   = 2'b00;
    h    = 1'b0;
    ls   = 1'b0;
    lh   = 1'b0;
    done = 1'b0;
    busy = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        lx   = 1'b1;
        busy = 1'b1;
      end
      S_MUL_AX: begin
        m0   = 2'b01;
        h    = 1'b1;
        lh   = 1'b1;
        busy = 1'b1;
      end
      S_ADD_B: begin
        m1   = 2'b11;
        m2   = 2'b01;
        m0   = 2'b10;
        ls   = mode_q;
        lh   = ~mode_q;
        busy = 1'b1;
      end
      S_MUL_HX: begin
        m1   = 2'b11;
        h    = 1'b1;
        lh   = 1'b1;
        busy = 1'b1;
      end
      S_ADD_C: begin
        m1   = 2'b11;
        m2   = 2'b01;
        m0   = 2'b11;
        ls   = 1'b1;
        busy = 1'b1;
      end
      S_FIM: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_poli.sv
// tb/tb_controle_poli.sv - randomized bench for controle_poli against a step-sequence and datapath model
module tb_controle_poli;

  logic       ck, rst, start, lin;
  logic       lx, h, ls, lh, done, busy;
  logic [1:0] m0, m1, m2;

  controle_poli dut (
    .ck(ck), .rst(rst), .start(start), .lin(lin),
    .lx(lx), .m0(m0), .m1(m1), .m2(m2), .h(h),
    .ls(ls), .lh(lh), .done(done), .busy(busy)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  localparam int ST_IDLE = 0, ST_LOAD = 1, ST_MUL_AX = 2, ST_ADD_BQ = 3,
                 ST_ADD_BL = 4, ST_MUL_HX = 5, ST_ADD_C = 6, ST_FIM = 7;

  int checks = 0;
  int failures = 0;
  int q[$];
  int cur = ST_IDLE;
  int a_v, b_v, c_v, x_in, exp_res;
  int reg_x, reg_s, reg_h;
  logic [11:0] prev_ctrl = '0;
  int cyc, done_n, last_done;
  int done_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ctrl_now();
    return {lx, m0, m1, m2, h, ls, lh, done, busy};
  endfunction

  // expected control word for each evaluation step, straight from the step table
  function automatic logic [11:0] ctrl_of(input int st);
    logic lx_e, h_e, ls_e, lh_e, dn_e, bs_e;
    logic [1:0] m0_e, m1_e, m2_e;
    lx_e = 0; h_e = 0; ls_e = 0; lh_e = 0; dn_e = 0;
    m0_e = 0; m1_e = 0; m2_e = 0;
    bs_e = (st != ST_IDLE);
    case (st)
      ST_LOAD:   lx_e = 1;
      ST_MUL_AX: begin m0_e = 2'b01; h_e = 1; lh_e = 1; end
      ST_ADD_BQ: begin m1_e = 2'b11; m2_e = 2'b01; m0_e = 2'b10; lh_e = 1; end
      ST_ADD_BL: begin m1_e = 2'b11; m2_e = 2'b01; m0_e = 2'b10; ls_e = 1; end
      ST_MUL_HX: begin m1_e = 2'b11; h_e = 1; lh_e = 1; end
      ST_ADD_C:  begin m1_e = 2'b11; m2_e = 2'b01; m0_e = 2'b11; ls_e = 1; end
      ST_FIM:    dn_e = 1;
      default: ;
    endcase
    return {lx_e, m0_e, m1_e, m2_e, h_e, ls_e, lh_e, dn_e, bs_e};
  endfunction

  function automatic int kon(input logic [1:0] s);
    case (s)
      2'b01:   return a_v;
      2'b10:   return b_v;
      2'b11:   return c_v;
      default: return 0;
    endcase
  endfunction

  task automatic cycle();
    int op1, op2, res;
    @(posedge ck);
    #1;
    // datapath reacts to the controls that were present before this edge
    case (prev_ctrl[8:7])
      2'b00: op1 = kon(prev_ctrl[10:9]);
      2'b01: op1 = reg_x;
      2'b10: op1 = reg_s;
      default: op1 = reg_h;
    endcase
    case (prev_ctrl[6:5])
      2'b00: op2 = reg_x;
      2'b01: op2 = kon(prev_ctrl[10:9]);
      2'b10: op2 = reg_s;
      default: op2 = reg_h;
    endcase
    res = prev_ctrl[4] ? op1 * op2 : op1 + op2;
    if (prev_ctrl[11]) reg_x = x_in;
    if (prev_ctrl[3])  reg_s = res;
    if (prev_ctrl[2])  reg_h = res;
    cyc++;
    if (!rst) begin
      cur = ST_IDLE;
      q.delete();
    end else begin
      if (cur == ST_IDLE && start) begin
        if (lin) begin
          q = '{ST_LOAD, ST_MUL_AX, ST_ADD_BL, ST_FIM};
          exp_res = a_v * x_in + b_v;
        end else begin
          q = '{ST_LOAD, ST_MUL_AX, ST_ADD_BQ, ST_MUL_HX, ST_ADD_C, ST_FIM};
          exp_res = a_v * x_in * x_in + b_v * x_in + c_v;
        end
      end
      cur = (q.size() > 0) ? q.pop_front() : ST_IDLE;
    end
    check("ctrl", ctrl_now(), ctrl_of(cur));
    check("ls_lh", ls & lh, 0);
    if (done) begin
      done_n++;
      last_done = cyc;
      done_q.push_back(cyc);
      check("result", reg_s, exp_res);
    end
    prev_ctrl = ctrl_now();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_async", ctrl_now(), 0);
    check("rst_busy", busy, 0);
    cur = ST_IDLE;
    q.delete();
    prev_ctrl = '0;
  endtask

  task automatic launch(input logic mode);
    lin = mode; start = 1'b1;
    cyc = 0; done_n = 0; last_done = 0; done_q.delete();
    cycle();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; lin = 1'b0;
    a_v = 0; b_v = 0; c_v = 0; x_in = 0;
    reg_x = 0; reg_s = 0; reg_h = 0;
    #2;
    check("reset_state", ctrl_now(), 0);
    cycle(); cycle();
    rst = 1'b1;

    a_v = 2; b_v = 3; c_v = 4; x_in = 5;
    launch(1'b0);
    repeat (8) cycle();
    check("quad_latency", last_done, 6);
    check("quad_done_cnt", done_n, 1);
    check("quad_69", reg_s, 69);

    launch(1'b1);
    repeat (6) cycle();
    check("lin_latency", last_done, 4);
    check("lin_done_cnt", done_n, 1);
    check("lin_13", reg_s, 13);

    launch(1'b0);
    cycle();
    start = 1'b1; lin = 1'b1;
    cycle();
    start = 1'b0; lin = 1'b0;
    repeat (3) cycle();
    start = 1'b1; lin = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    check("ignore_done_cnt", done_n, 1);
    check("ignore_latency", last_done, 6);

    lin = 1'b0; start = 1'b1;
    cyc = 0; done_n = 0; done_q.delete();
    repeat (20) cycle();
    start = 1'b0;
    repeat (8) cycle();
    check("b2b_cnt", done_n, 3);
    if (done_q.size() >= 2) begin
      check("b2b_first", done_q[0], 6);
      check("b2b_second", done_q[1], 13);
    end else begin
      check("b2b_dones_seen", done_q.size(), 2);
    end

    launch(1'b0);
    repeat (3) cycle();
    #2;
    do_reset();
    cycle();
    rst = 1'b1;
    launch(1'b0);
    repeat (7) cycle();
    check("rst_restart_latency", last_done, 6);

    launch(1'b0);
    repeat (4) cycle();
    do_reset();
    cycle();
    check("abort_no_done", done_n, 0);
    rst = 1'b1;
    launch(1'b0);
    repeat (7) cycle();
    check("abort_latency", last_done, 6);
    check("abort_done_cnt", done_n, 1);

    for (int i = 0; i < 600; i++) begin
      if (cur == ST_IDLE) begin
        a_v = $urandom_range(0, 15); b_v = $urandom_range(0, 15);
        c_v = $urandom_range(0, 15); x_in = $urandom_range(0, 15);
      end
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
        cycle();
        rst = 1'b1;
      end
      start = ($urandom_range(0, 2) != 0);
      lin = $urandom_range(0, 1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
